// File: rtl/imm_decode_ctrl_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for imm_decode_ctrl.
// master = surrounding pipeline (IF/EX side), slave = the decoder.
interface imm_decode_ctrl_if #(
  parameter int PC_W = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [PC_W-1:0] if_pc;
  logic            id_valid;
  logic            ex_ready;
  logic [31:0]     id_imm;
  logic [2:0]      id_sext_op;
  logic [4:0]      id_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [PC_W-1:0] id_pc;
  logic            id_illegal;

  modport master (
    output if_valid, if_inst, if_pc, ex_ready,
    input  if_ready, id_valid, id_imm, id_sext_op,
    input  id_rd, id_rs1, id_rs2, id_pc, id_illegal
  );

  modport slave (
    input  if_valid, if_inst, if_pc, ex_ready,
    output if_ready, id_valid, id_imm, id_sext_op,
    output id_rd, id_rs1, id_rs2, id_pc, id_illegal
  );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Decode front end: opcode class, immediate extension, 2-entry skid queue.
// Define IMM_DECODE_PERF_EN to add the perf_stall/perf_illegal counters.
module imm_decode_ctrl #(
  parameter int PC_W = 32
`ifdef IMM_DECODE_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  imm_decode_ctrl_if.slave bus
`ifdef IMM_DECODE_PERF_EN
  , output logic [CNT_W-1:0] perf_stall
  , output logic [CNT_W-1:0] perf_illegal
`endif
);

  typedef struct packed {
    logic [31:0]     imm;
    logic [2:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [PC_W-1:0] pc;
    logic            ill;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } st_t;

  function automatic ent_t decode(
    input logic [31:0]     inst,
    input logic [PC_W-1:0] pc
  );
    ent_t        e;
    logic [24:0] d;
    logic [6:0]  opc;
    d      = inst[31:7];
    opc    = inst[6:0];
    e      = '0;
    e.rd   = inst[11:7];
    e.rs1  = inst[19:15];
    e.rs2  = inst[24:20];
    e.pc   = pc;
    unique case (1'b1)
      (opc == 7'b0010011),
      (opc == 7'b0000011),
      (opc == 7'b1100111): begin
        e.op  = 3'b000;
        e.imm = {{20{d[24]}}, d[24:13]};
      end
      (opc == 7'b0100011): begin
        e.op  = 3'b010;
        e.imm = {{20{d[24]}}, d[24:18], d[4:0]};
      end
      (opc == 7'b1100011): begin
        e.op  = 3'b110;
        e.imm = {{20{d[24]}}, d[0], d[23:18], d[4:1], 1'b0};
      end
      (opc == 7'b0110111),
      (opc == 7'b0010111): begin
        e.op  = 3'b011;
        e.imm = {d[24:5], 12'h0};
      end
      (opc == 7'b1101111): begin
        e.op  = 3'b111;
        e.imm = {{12{d[24]}}, d[12:5], d[13], d[23:14], 1'b0};
      end
      default: begin
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  st_t  state_q, state_d;
  ent_t head_q, head_d;
  ent_t tail_q, tail_d;
  ent_t new_e;
  logic push;
  logic pop;

  assign bus.if_ready   = (state_q != FULL);
  assign bus.id_valid   = (state_q != EMPTY);
  assign bus.id_imm     = head_q.imm;
  assign bus.id_sext_op = head_q.op;
  assign bus.id_rd      = head_q.rd;
  assign bus.id_rs1     = head_q.rs1;
  assign bus.id_rs2     = head_q.rs2;
  assign bus.id_pc      = head_q.pc;
  assign bus.id_illegal = head_q.ill;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    new_e   = decode(bus.if_inst, bus.if_pc);
    push    = bus.if_valid && bus.if_ready;
    pop     = bus.id_valid && bus.ex_ready;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = new_e;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = new_e;
          end else if (push) begin
            tail_d  = new_e;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef IMM_DECODE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] illc_q, illc_d;

  // Illegal count tracks entries that actually enter the queue.
  always_comb begin
    stall_d = stall_q;
    illc_d  = illc_q;
    if (bus.if_valid && !bus.if_ready && (stall_q != '1))
      stall_d = stall_q + CNT_ONE;
    if (push && !flush && new_e.ill && (illc_q != '1))
      illc_d = illc_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      illc_q  <= '0;
    end else begin
      stall_q <= stall_d;
      illc_q  <= illc_d;
    end
  end

  assign perf_stall   = stall_q;
  assign perf_illegal = illc_q;
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_imm_decode_ctrl;

  logic clk;
  logic rst_n;
  logic flush;

  imm_decode_ctrl_if #(.PC_W(32)) bus ();

`ifdef IMM_DECODE_PERF_EN
  logic [15:0] perf_stall;
  logic [15:0] perf_illegal;
`endif

  imm_decode_ctrl #(.PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef IMM_DECODE_PERF_EN
    , .perf_stall   (perf_stall)
    , .perf_illegal (perf_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ill;
  } vec_t;

  int   checks;
  int   errors;
  exp_t mq[$];
  int   stall_m;
  int   ill_m;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode written from the ISA field layout with signed shifts.
  function automatic exp_t ref_dec(input logic [31:0] inst,
                                   input logic [31:0] pc);
    exp_t e;
    e.rd  = inst[11:7];
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.pc  = pc;
    e.ill = 1'b0;
    e.imm = 32'h0;
    e.op  = 3'b000;
    case (inst[6:0])
      7'h13, 7'h03, 7'h67: e.imm = $signed(inst) >>> 20;
      7'h23: begin
        e.op  = 3'b010;
        e.imm = $signed({inst[31:25], inst[11:7], 20'h0}) >>> 20;
      end
      7'h63: begin
        e.op  = 3'b110;
        e.imm = $signed({inst[31], inst[7], inst[30:25],
                         inst[11:8], 20'h0}) >>> 19;
      end
      7'h37, 7'h17: begin
        e.op  = 3'b011;
        e.imm = inst & 32'hFFFFF000;
      end
      7'h6F: begin
        e.op  = 3'b111;
        e.imm = $signed({inst[31], inst[19:12], inst[20],
                         inst[30:21], 12'h0}) >>> 11;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check_out();
    chk("if_ready", 64'(bus.if_ready), 64'(mq.size() < 2));
    chk("id_valid", 64'(bus.id_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("id_imm", 64'(bus.id_imm), 64'(mq[0].imm));
      chk("id_sext_op", 64'(bus.id_sext_op), 64'(mq[0].op));
      chk("id_rd", 64'(bus.id_rd), 64'(mq[0].rd));
      chk("id_rs1", 64'(bus.id_rs1), 64'(mq[0].rs1));
      chk("id_rs2", 64'(bus.id_rs2), 64'(mq[0].rs2));
      chk("id_pc", 64'(bus.id_pc), 64'(mq[0].pc));
      chk("id_illegal", 64'(bus.id_illegal), 64'(mq[0].ill));
    end
`ifdef IMM_DECODE_PERF_EN
    chk("perf_stall", 64'(perf_stall), 64'(stall_m));
    chk("perf_illegal", 64'(perf_illegal), 64'(ill_m));
`endif
  endtask

  // One clock: check current outputs, drive inputs, advance model.
  task automatic cycle(input logic v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic exr,
                       input logic fl);
    bit   rdy;
    bit   pop;
    bit   push;
    exp_t e;
    check_out();
    bus.if_valid = v;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    bus.ex_ready = exr;
    flush        = fl;
    rdy  = mq.size() < 2;
    pop  = (mq.size() > 0) && exr;
    push = v && rdy;
    if (v && !rdy && stall_m < 65535) stall_m++;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e = ref_dec(inst, pc);
        mq.push_back(e);
        if (e.ill && ill_m < 65535) ill_m++;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic exr);
    cycle(1'b0, 32'h0, 32'h0, exr, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_id_valid"}, 64'(bus.id_valid), 64'(0));
    chk({tag, "_if_ready"}, 64'(bus.if_ready), 64'(1));
    chk({tag, "_id_imm"}, 64'(bus.id_imm), 64'(0));
    chk({tag, "_id_op"}, 64'(bus.id_sext_op), 64'(0));
    chk({tag, "_id_regs"},
        64'({bus.id_rd, bus.id_rs1, bus.id_rs2}), 64'(0));
    chk({tag, "_id_pc"}, 64'(bus.id_pc), 64'(0));
    chk({tag, "_id_illegal"}, 64'(bus.id_illegal), 64'(0));
`ifdef IMM_DECODE_PERF_EN
    chk({tag, "_perf"}, 64'({perf_stall, perf_illegal}), 64'(0));
`endif
  endtask

  vec_t        tbl[6];
  logic [6:0]  opcs[10];
  exp_t        first;
`ifdef IMM_DECODE_PERF_EN
  int          ill_base;
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    stall_m = 0;
    ill_m   = 0;
    tbl[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'b000, 5'd1,  5'd0, 5'd31, 1'b0};
    tbl[1] = '{32'hFE112E23, 32'hFFFFFFFC, 3'b010, 5'd28, 5'd2, 5'd1,  1'b0};
    tbl[2] = '{32'hFE000CE3, 32'hFFFFFFF8, 3'b110, 5'd25, 5'd0, 5'd0,  1'b0};
    tbl[3] = '{32'h123452B7, 32'h12345000, 3'b011, 5'd5,  5'd8, 5'd3,  1'b0};
    tbl[4] = '{32'h001000EF, 32'h00000800, 3'b111, 5'd1,  5'd0, 5'd1,  1'b0};
    tbl[5] = '{32'h0000007F, 32'h00000000, 3'b000, 5'd0,  5'd0, 5'd0,  1'b1};
    opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
             7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    rst_n        = 1'b0;
    flush        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_inst  = 32'h0;
    bus.if_pc    = 32'h0;
    bus.ex_ready = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Directed table: push into EMPTY, visible next cycle, then pop.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, tbl[i].inst, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
      chk("tbl_valid", 64'(bus.id_valid), 64'(1));
      chk("tbl_imm", 64'(bus.id_imm), 64'(tbl[i].imm));
      chk("tbl_op", 64'(bus.id_sext_op), 64'(tbl[i].op));
      chk("tbl_regs", 64'({bus.id_rd, bus.id_rs1, bus.id_rs2}),
          64'({tbl[i].rd, tbl[i].rs1, tbl[i].rs2}));
      chk("tbl_ill", 64'(bus.id_illegal), 64'(tbl[i].ill));
      idle(1'b1);
    end

    // Back-to-back stream at full throughput.
    cycle(1'b1, 32'hFE000CE3, 32'h2000, 1'b1, 1'b0);
    cycle(1'b1, 32'h123452B7, 32'h2004, 1'b1, 1'b0);
    cycle(1'b1, 32'h001000EF, 32'h2008, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // EX stalled: two accepted, third held off, head frozen, then drain.
    first = ref_dec(32'hFFF00093, 32'h3000);
    cycle(1'b1, 32'hFFF00093, 32'h3000, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE112E23, 32'h3004, 1'b0, 1'b0);
    cycle(1'b1, 32'h123452B7, 32'h3008, 1'b0, 1'b0);
    chk("stall_if_ready", 64'(bus.if_ready), 64'(0));
    chk("stall_frozen_imm", 64'(bus.id_imm), 64'(first.imm));
    chk("stall_frozen_pc", 64'(bus.id_pc), 64'(32'h3000));
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush while FULL with an instruction offered.
    cycle(1'b1, 32'hFFF00093, 32'h4000, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE112E23, 32'h4004, 1'b0, 1'b0);
    cycle(1'b1, 32'h001000EF, 32'h4008, 1'b0, 1'b1);
    chk("flush_id_valid", 64'(bus.id_valid), 64'(0));
    chk("flush_if_ready", 64'(bus.if_ready), 64'(1));
    idle(1'b1);

    // Two illegal opcodes.
`ifdef IMM_DECODE_PERF_EN
    ill_base = int'(perf_illegal);
`endif
    cycle(1'b1, 32'h0000007F, 32'h5000, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000007F, 32'h5004, 1'b0, 1'b0);
    chk("illegal_flag", 64'(bus.id_illegal), 64'(1));
    chk("illegal_imm", 64'(bus.id_imm), 64'(0));
`ifdef IMM_DECODE_PERF_EN
    chk("perf_illegal_delta", 64'(int'(perf_illegal) - ill_base), 64'(2));
`endif

    // Asynchronous reset while FULL drops everything.
    bus.if_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    mq.delete();
    stall_m = 0;
    ill_m   = 0;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] inst;
      inst      = $urandom;
      inst[6:0] = opcs[$urandom_range(0, 9)];
      cycle(($urandom_range(0, 3) != 0), inst, $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
    end
    check_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
